// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and request bundle
// for the ALU host sequencer.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SEND_X,
    SEND_Y,
    WAIT,
    CAP_HI,
    CAP_LO,
    RESP
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] x;
    logic [7:0] y;
  } req_t;

endpackage

// File: rtl/alu_host_seq_wait_timer.sv
// WAIT-state cycle counter; expired flags the
// last permitted cycle while counting.
module wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/alu_host_seq.sv
// Request/response sequencer driving a byte-serial
// ALU: sends X then Y, waits, captures two result bytes.
module alu_host_seq
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_x,
  input  logic [7:0]  req_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  alu_in,
  output logic [1:0]  alu_op,
  output logic        alu_valid,
  input  logic        alu_ready,
  input  logic [7:0]  alu_o
);

  state_t     state;
  state_t     nxt;
  req_t       req;
  logic [7:0] hi;
  logic [7:0] lo;
  logic       err;
  logic       expired;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == SEND_Y),
    .en     (state == WAIT),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req <= '0;
      hi  <= '0;
      lo  <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        req <= {req_op, req_x, req_y};
      end
      // ready beats timeout when both land on the last cycle
      if (state == WAIT) begin
        if (alu_ready) begin
          hi  <= alu_o;
          err <= 1'b0;
        end else if (expired) begin
          hi  <= '0;
          lo  <= '0;
          err <= 1'b1;
        end
      end
      if (state == CAP_LO) begin
        lo <= alu_o;
      end
    end
  end

  always_comb begin
    nxt       = state;
    req_ready = 1'b0;
    alu_valid = 1'b0;
    alu_in    = '0;
    alu_op    = OP_ADD;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nxt = SEND_X;
      end
      SEND_X: begin
        alu_valid = 1'b1;
        alu_in    = req.x;
        alu_op    = req.op;
        nxt       = SEND_Y;
      end
      SEND_Y: begin
        alu_in = req.y;
        alu_op = req.op;
        nxt    = WAIT;
      end
      WAIT: begin
        alu_op = req.op;
        if (alu_ready) nxt = CAP_LO;
        else if (expired) nxt = RESP;
      end
      CAP_LO: nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = {hi, lo};
        rsp_err   = err;
        if (rsp_ready) nxt = IDLE;
      end
      // CAP_HI is folded into the WAIT exit and never entered
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_host_seq.sv
// Scoreboard bench for alu_host_seq with a
// reactive byte-serial ALU model.
module tb_alu_host_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_x;
  logic [7:0]  req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  alu_in;
  logic [1:0]  alu_op;
  logic        alu_valid;
  logic        alu_ready;
  logic [7:0]  alu_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] exp_q[$];

  logic [1:0] m_op;
  logic [7:0] m_x;
  logic [7:0] m_y;
  int         m_dly;

  alu_host_seq #(
    .TIMEOUT(64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_x    (req_x),
    .req_y    (req_y),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .alu_in   (alu_in),
    .alu_op   (alu_op),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_o    (alu_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(logic [1:0] op,
                                          logic [7:0] x,
                                          logic [7:0] y);
    case (op)
      2'b00:   return {8'h0, x} + {8'h0, y};
      2'b01:   return {8'h0, x} - {8'h0, y};
      2'b10:   return {8'h0, x} * {8'h0, y};
      default: return (y == 0) ? 16'hFFFF : {x % y, x / y};
    endcase
  endfunction

  // ALU model: checks the X/Y handoff, answers after m_dly WAIT cycles
  initial begin
    logic [15:0] r;
    alu_ready = 1'b0;
    alu_o     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (alu_valid) begin
        check("alu_in_x", alu_in, m_x);
        check("alu_op_x", alu_op, m_op);
        @(posedge clk);
        #1;
        check("alu_valid_1cyc", alu_valid, 0);
        check("alu_in_y", alu_in, m_y);
        if (m_dly >= 0) begin
          r = alu_ref(m_op, m_x, m_y);
          @(posedge clk);
          #1;
          check("alu_in_wait", alu_in, 0);
          for (int i = 0; i < m_dly; i++) begin
            @(posedge clk);
            #1;
          end
          alu_ready = 1'b1;
          alu_o     = r[15:8];
          @(posedge clk);
          #1;
          alu_ready = 1'b0;
          alu_o     = r[7:0];
          @(posedge clk);
          #1;
          alu_o = '0;
        end
      end
    end
  end

  task automatic do_req(logic [1:0] op, logic [7:0] x, logic [7:0] y,
                        int dly, bit push);
    int t;
    t     = 0;
    m_op  = op;
    m_x   = x;
    m_y   = y;
    m_dly = dly;
    while (!req_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("accepted", req_ready, 0);
    if (push) begin
      if (dly < 0) exp_q.push_back({1'b1, 16'h0000});
      else exp_q.push_back({1'b0, alu_ref(op, x, y)});
    end
  endtask

  task automatic get_rsp(int exp_lat, int bp);
    int n;
    logic [16:0] e;
    logic [15:0] d0;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rsp_seen", rsp_valid, 1);
    check("latency", n, exp_lat);
    if (exp_q.size() == 0) begin
      check("q_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("rsp_data", rsp_data, e[15:0]);
      check("rsp_err", rsp_err, e[16]);
    end
    d0 = rsp_data;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, d0);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("idle_after_ack", req_ready, 1);
    check("rsp_dropped", rsp_valid, 0);
  endtask

  initial begin
    int seen;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;
    m_op      = '0;
    m_x       = '0;
    m_y       = '0;
    m_dly     = -1;
    #23;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_alu_valid", alu_valid, 0);
    check("rst_alu_in", alu_in, 0);
    check("rst_alu_op", alu_op, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_req(2'b00, 8'h05, 8'h03, 0, 1);
    get_rsp(4, 0);

    do_req(2'b10, 8'h12, 8'h34, 20, 1);
    get_rsp(24, 0);

    do_req(2'b11, 8'h64, 8'h07, -1, 1);
    get_rsp(66, 0);

    do_req(2'b11, 8'h64, 8'h07, 3, 1);
    get_rsp(7, 5);

    do_req(2'b01, 8'h10, 8'h20, 63, 1);
    get_rsp(67, 0);

    do_req(2'b00, 8'hAA, 8'h55, -1, 0);
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_alu_op", alu_op, 0);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    check("no_rsp_after_rst", seen, 0);

    do_req(2'b00, 8'hFF, 8'h02, 5, 1);
    get_rsp(9, 1);

    check("q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_host_seq.md
ALU_HOST_SEQ -- requirements
Module: alu_host_seq

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles allowed for alu_ready before an error response is returned.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  sequencer accepts a request (IDLE only).
REQ-006 req_op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 req_x  input  8  first operand, destined for the ALU Q register.
REQ-008 req_y  input  8  second operand, destined for the ALU M register.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  downstream accepts the response.
REQ-011 rsp_data  output  16  result, {A byte, Q byte}.
REQ-012 rsp_err  output  1  1 = ALU timed out.
REQ-013 alu_in  output  8  operand bus driven to the ALU.
REQ-014 alu_op  output  2  opcode driven to the ALU.
REQ-015 alu_valid  output  1  start pulse to the ALU.
REQ-016 alu_ready  input  1  ALU done flag.
REQ-017 alu_o  input  8  ALU result bus.

Function
REQ-018 The FSM shall have seven states: IDLE, SEND_X, SEND_Y, WAIT, CAP_HI, CAP_LO, RESP. CAP_HI is merged into the WAIT exit, as REQ-023 details.
REQ-019 req_ready shall be 1 only in IDLE; on req_valid&&req_ready, op/x/y shall be latched and the FSM shall go to SEND_X.
REQ-020 SEND_X (1 cycle): alu_valid=1, alu_in=x, alu_op=op; next state SEND_Y.
REQ-021 SEND_Y (1 cycle): alu_valid=0, alu_in=y, alu_op=op; next state WAIT.
REQ-022 WAIT: alu_in=0, alu_op=op held, wait counter incremented each cycle from 0.
REQ-023 WAIT with alu_ready=1: alu_o shall be captured as the high byte, and the FSM shall go to CAP_LO.
REQ-024 CAP_LO (1 cycle): alu_o shall be captured as the low byte, and the FSM shall go to RESP with rsp_err=0.
REQ-025 WAIT with the counter at TIMEOUT-1 and alu_ready=0: the FSM shall go to RESP with rsp_data=0 and rsp_err=1.
REQ-026 If alu_ready=1 and timeout occur in the same cycle, alu_ready shall win.
REQ-027 alu_ready shall be ignored outside WAIT.
REQ-028 RESP: rsp_valid=1, with rsp_data/rsp_err held stable until rsp_ready=1; then the FSM shall go to IDLE.
REQ-029 A new request shall not be accepted in the cycle a response completes; minimum request-to-request spacing is therefore 6 cycles.
REQ-030 Outside the states listed above, alu_valid shall be 0, alu_in shall be 0 and alu_op shall be 00.
REQ-031 The wait counter shall be ceil(log2(TIMEOUT)) bits wide and shall be cleared on entry to WAIT.

Reset
REQ-032 With rst=0, the FSM shall go to IDLE asynchronously.
REQ-033 During reset, all outputs shall be 0 except req_ready, which shall be 1 once the FSM is in IDLE.
REQ-034 During reset, the latched operands, the captured bytes and the counter shall be 0.
REQ-035 A reset in any state shall abort the transaction with no response emitted.

Structure
REQ-036 The opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the FSM state encoding shall live in the shared package alu_pkg.
REQ-037 The wait counter shall be a separate sub-module, wait_timer, with ports clk, rst, clr, en, expired.

Verification
REQ-038 Add: op=00, x=0x05, y=0x03; the ALU model asserts alu_ready with o=0x00 then 0x08 -> rsp_data=0x0008, rsp_err=0, with alu_valid high exactly one cycle and alu_in sequence 0x05, 0x03.
REQ-039 Multiply: op=10, x=0x12, y=0x34; the model returns 0x03 then 0xA8 after 20 cycles -> rsp_data=0x03A8, rsp_err=0.
REQ-040 Timeout: op=11, alu_ready never asserted -> RESP entered after exactly 64 WAIT cycles, with rsp_err=1 and rsp_data=0x0000.
REQ-041 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable and req_ready=0 throughout, then IDLE one cycle after rsp_ready=1.
REQ-042 Reset mid-WAIT: rst pulled low in WAIT cycle 10 -> IDLE immediately, no rsp_valid, and a following request completes normally.
REQ-043 Coincidence: alu_ready=1 in WAIT cycle 63 -> normal capture with rsp_err=0.
